// File: rtl/mips_hazard_pkg.sv
// Shared types and select encodings for the EX-stage forwarding/hazard controller.
package mips_hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int SHADOW_AW = 5;

  // Control-only view of an in-flight instruction; v=0 marks a bubble.
  typedef struct packed {
    logic                 v;
    logic [SHADOW_AW-1:0] dst;
    logic                 rw;
    logic                 mr;
  } shadow_t;

endpackage

// File: rtl/hz_shadow_stage.sv
// One stage of the control shadow pipeline: holds while frozen, loads an empty
// entry when a bubble is requested.
module hz_shadow_stage
  import mips_hazard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  input  logic    bubble_i,
  input  shadow_t d_i,
  output shadow_t q_o
);

  shadow_t stage_q;
  shadow_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d = bubble_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for the EX stage,
// driven from a shadow copy of the EX/MEM/WB destination fields.
module fwd_hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW = SHADOW_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_wait,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  shadow_t ex_q, mem_q, wb_q;
  shadow_t id_ent;
  logic    advance;
  logic    ex_bubble;
  logic    load_use;

  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Newest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] r,
                                         input shadow_t ex, input shadow_t mem);
    logic [SHADOW_AW-1:0] rr;
    rr      = SHADOW_AW'(r);
    fwd_sel = FWD_RF;
    if (used && rr != '0) begin
      if (ex.v && ex.rw && ex.dst == rr) begin
        fwd_sel = FWD_EXMEM;
      end else if (mem.v && mem.rw && mem.dst == rr) begin
        fwd_sel = FWD_MEMWB;
      end
    end
    return fwd_sel;
  endfunction

  assign id_ent = '{v: 1'b1, dst: SHADOW_AW'(id_dst), rw: id_regwrite, mr: id_memread};

  assign load_use = id_valid && ex_q.v && ex_q.mr && ex_q.rw && ex_q.dst != '0 &&
                    ((id_rs_used && ex_q.dst == SHADOW_AW'(id_rs)) ||
                     (id_rt_used && ex_q.dst == SHADOW_AW'(id_rt)));

  // A taken branch kills the ID instruction, so flush takes precedence over stall.
  assign flush_if_id = !rst && ex_branch_taken && !mem_wait;
  assign stall_if_id = !rst && load_use && !ex_branch_taken && !mem_wait;
  assign bubble_ex   = !rst && (load_use || ex_branch_taken) && !mem_wait;

  assign advance   = !mem_wait;
  assign ex_bubble = !id_valid || bubble_ex;

  hz_shadow_stage u_ex_stage (
    .clk      (clk),
    .rst      (rst),
    .en_i     (advance),
    .bubble_i (ex_bubble),
    .d_i      (id_ent),
    .q_o      (ex_q)
  );

  hz_shadow_stage u_mem_stage (
    .clk      (clk),
    .rst      (rst),
    .en_i     (advance),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hz_shadow_stage u_wb_stage (
    .clk      (clk),
    .rst      (rst),
    .en_i     (advance),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (advance) begin
      fwd_a_d = bubble_ex ? FWD_RF : fwd_sel(id_rs_used, id_rs, ex_q, mem_q);
      fwd_b_d = bubble_ex ? FWD_RF : fwd_sel(id_rt_used, id_rt, ex_q, mem_q);
    end
    if (stall_if_id && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: each cycle's expected outputs are queued as the ID
// instruction is driven, then popped and compared mid-cycle.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_rs_used, id_rt_used, id_regwrite, id_memread;
  logic        ex_branch_taken, mem_wait;
  logic        stall_if_id, bubble_ex, flush_if_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_wait        (mem_wait),
    .stall_if_id     (stall_if_id),
    .bubble_ex       (bubble_ex),
    .flush_if_id     (flush_if_id),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic setInstr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu, input logic [4:0] dst,
                          input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rs_used  = rsu;
    id_rt_used  = rtu;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic setNop();
    setInstr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs are already driven (just after a rising edge); compare at the falling edge.
  task automatic applyStimulus(input string tag, input logic stall, input logic bubble,
                               input logic flush, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [15:0] cnt);
    exp_t e;
    e = '{tag: tag, stall: stall, bubble: bubble, flush: flush, fa: fa, fb: fb, cnt: cnt};
    expQ.push_back(e);
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput({e.tag, ".stall"},  32'(stall_if_id), 32'(e.stall));
    checkOutput({e.tag, ".bubble"}, 32'(bubble_ex),   32'(e.bubble));
    checkOutput({e.tag, ".flush"},  32'(flush_if_id), 32'(e.flush));
    checkOutput({e.tag, ".fwdA"},   32'(fwd_a_sel),   32'(e.fa));
    checkOutput({e.tag, ".fwdB"},   32'(fwd_b_sel),   32'(e.fb));
    checkOutput({e.tag, ".cnt"},    32'(stall_count), 32'(e.cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_branch_taken = 1'b0;
    mem_wait = 1'b0;
    setNop();
    repeat (2) @(posedge clk);
    #1;

    ex_branch_taken = 1'b1;
    applyStimulus("rst_hold", 0, 0, 0, 2'b00, 2'b00, 16'd0);
    ex_branch_taken = 1'b0;
    rst = 1'b0;

    // add r3 ; sub r4,r3,r1
    setInstr(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  applyStimulus("t1_add",  0, 0, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0);  applyStimulus("t1_sub",  0, 0, 0, 2'b00, 2'b00, 16'd0);
    setNop();                                   applyStimulus("t1_ex",   0, 0, 0, 2'b01, 2'b00, 16'd0);

    // add r3 ; nop ; or r5,r1,r3 then two r3 producers in flight
    setInstr(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  applyStimulus("t2_add",  0, 0, 0, 2'b00, 2'b00, 16'd0);
    setNop();                                   applyStimulus("t2_nop",  0, 0, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd1, 5'd3, 1, 1, 5'd5, 1, 0);  applyStimulus("t2_or",   0, 0, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  applyStimulus("t2_orEx", 0, 0, 0, 2'b00, 2'b10, 16'd0);
    setInstr(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);  applyStimulus("t2_add2", 0, 0, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd3, 5'd3, 1, 1, 5'd7, 1, 0);  applyStimulus("t2_sub",  0, 0, 0, 2'b00, 2'b00, 16'd0);
    setNop();                                   applyStimulus("t2_prio", 0, 0, 0, 2'b01, 2'b01, 16'd0);

    // lw r5 ; add r6,r5,r2
    setInstr(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1);  applyStimulus("t3_lw",   0, 0, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0);  applyStimulus("t3_stall",1, 1, 0, 2'b00, 2'b00, 16'd0);
    setInstr(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0);  applyStimulus("t3_issue",0, 0, 0, 2'b00, 2'b00, 16'd1);
    setNop();                                   applyStimulus("t3_ex",   0, 0, 0, 2'b10, 2'b00, 16'd1);

    // r0 destinations never forward or stall
    setInstr(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);  applyStimulus("t4_addr0",0, 0, 0, 2'b00, 2'b00, 16'd1);
    setInstr(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0);  applyStimulus("t4_rd0",  0, 0, 0, 2'b00, 2'b00, 16'd1);
    setInstr(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);  applyStimulus("t4_lwr0", 0, 0, 0, 2'b00, 2'b00, 16'd1);
    setInstr(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);  applyStimulus("t4_use0", 0, 0, 0, 2'b00, 2'b00, 16'd1);
    setNop();                                   applyStimulus("t4_ex",   0, 0, 0, 2'b00, 2'b00, 16'd1);

    // load-use coinciding with a taken branch
    setInstr(1, 5'd1, 5'd0, 1, 0, 5'd10, 1, 1); applyStimulus("t5_lw",   0, 0, 0, 2'b00, 2'b00, 16'd1);
    setInstr(1, 5'd10, 5'd10, 1, 1, 5'd11, 1, 0);
    ex_branch_taken = 1'b1;                     applyStimulus("t5_br",   0, 1, 1, 2'b00, 2'b00, 16'd1);
    ex_branch_taken = 1'b0;
    setNop();                                   applyStimulus("t5_after",0, 0, 0, 2'b00, 2'b00, 16'd1);

    // load-use frozen by mem_wait for 3 cycles
    setInstr(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1); applyStimulus("t6_lw",   0, 0, 0, 2'b00, 2'b00, 16'd1);
    setInstr(1, 5'd1, 5'd12, 1, 1, 5'd13, 1, 0);
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("t6_wait%0d", i), 0, 0, 0, 2'b00, 2'b00, 16'd1);
    end
    mem_wait = 1'b0;                            applyStimulus("t6_stall",1, 1, 0, 2'b00, 2'b00, 16'd1);
                                                applyStimulus("t6_issue",0, 0, 0, 2'b00, 2'b00, 16'd2);
    setNop();                                   applyStimulus("t6_ex",   0, 0, 0, 2'b00, 2'b10, 16'd2);

    // branch held in EX across a freeze
    ex_branch_taken = 1'b1;
    mem_wait = 1'b1;                            applyStimulus("t6_brHold",0, 0, 0, 2'b00, 2'b00, 16'd2);
    mem_wait = 1'b0;                            applyStimulus("t6_brGo",  0, 1, 1, 2'b00, 2'b00, 16'd2);
    ex_branch_taken = 1'b0;

    // reset during a load-use stall
    setInstr(1, 5'd1, 5'd0, 1, 0, 5'd14, 1, 1); applyStimulus("t6_lw2",  0, 0, 0, 2'b00, 2'b00, 16'd2);
    setInstr(1, 5'd14, 5'd14, 1, 1, 5'd15, 1, 0);
    rst = 1'b1;                                 applyStimulus("t6_rst",  0, 0, 0, 2'b00, 2'b00, 16'd2);
    rst = 1'b0;                                 applyStimulus("t6_post", 0, 0, 0, 2'b00, 2'b00, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
